// File: rtl/step_scheduler.sv
// Step sequencer playback controller: turns BPM/loop configuration into a
// phase-accumulated step timebase and sequences start/pause/stop/done.
module step_scheduler #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned NUM_STEPS      = 16,
  parameter int unsigned STEPS_PER_BEAT = 4,
  parameter int unsigned STEP_W         = 4
) (
  input  logic              CLOCK_50,
  input  logic              nReset,
  input  logic [9:0]        BPM,
  input  logic [6:0]        Loops,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic              step_tick,
  output logic [STEP_W-1:0] step_idx,
  output logic [6:0]        loop_count,
  output logic              playing,
  output logic              paused,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Threshold is CLK_HZ*60 steps-per-minute units; computed in 64 bits to avoid int overflow.
  localparam logic [32:0]       THR      = 33'(64'(CLK_HZ) * 64'd60);
  localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_STEPS - 1);

  state_t              state_q, state_d;
  logic [32:0]         acc_q, acc_d;
  logic [9:0]          bpm_q, bpm_d;
  logic [6:0]          loops_q, loops_d;
  logic [STEP_W-1:0]   idx_q, idx_d;
  logic [6:0]          lc_q, lc_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                playing_q, playing_d;
  logic                paused_q, paused_d;

  logic [32:0]         inc_s;
  logic [32:0]         sum_s;
  logic                event_s;
  logic [6:0]          lc_next_s;
  logic                bpm_ok_s;

  assign inc_s     = 33'(bpm_q) * 33'(STEPS_PER_BEAT);
  assign sum_s     = acc_q + inc_s;
  assign event_s   = (sum_s >= THR);
  assign lc_next_s = (lc_q == 7'd127) ? lc_q : (lc_q + 7'd1);
  assign bpm_ok_s  = (BPM != 10'd0);

  // Next-state, timebase and pulse outputs.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bpm_d   = bpm_q;
    loops_d = loops_q;
    idx_d   = idx_q;
    lc_d    = lc_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      acc_d   = 33'd0;
      idx_d   = '0;
      lc_d    = 7'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && bpm_ok_s) begin
            state_d = ST_PLAY;
            acc_d   = 33'd0;
            idx_d   = '0;
            lc_d    = 7'd0;
            tick_d  = 1'b1;
            bpm_d   = BPM;
            loops_d = Loops;
          end else if (start) begin
            err_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        ST_PLAY: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (event_s) begin
            acc_d = sum_s - THR;
            // A zero tempo seen at a step boundary keeps the previous tempo.
            if (bpm_ok_s) begin
              bpm_d = BPM;
            end else begin
              bpm_d = bpm_q;
            end
            if (idx_q != LAST_IDX) begin
              idx_d  = idx_q + STEP_W'(1);
              tick_d = 1'b1;
            end else begin
              idx_d = '0;
              lc_d  = lc_next_s;
              if ((loops_q != 7'd0) && (lc_next_s == loops_q)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                tick_d = 1'b1;
              end
            end
          end else begin
            acc_d = sum_s;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_d = ST_PLAY;
            if (bpm_ok_s) begin
              bpm_d = BPM;
            end else begin
              bpm_d = bpm_q;
            end
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    playing_d = (state_d == ST_PLAY);
    paused_d  = (state_d == ST_PAUSE);
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      acc_q     <= 33'd0;
      bpm_q     <= 10'd0;
      loops_q   <= 7'd0;
      idx_q     <= '0;
      lc_q      <= 7'd0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      playing_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bpm_q     <= bpm_d;
      loops_q   <= loops_d;
      idx_q     <= idx_d;
      lc_q      <= lc_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      err_q     <= err_d;
      playing_q <= playing_d;
      paused_q  <= paused_d;
    end
  end

  assign step_tick  = tick_q;
  assign step_idx   = idx_q;
  assign loop_count = lc_q;
  assign playing    = playing_q;
  assign paused     = paused_q;
  assign done       = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Randomized and directed bench for step_scheduler against a behavioural
// reference of the playback rules (CLK_HZ=240, NUM_STEPS=4, STEPS_PER_BEAT=4).
module tb_step_scheduler;
  localparam int    CLK_HZ = 240;
  localparam int    NS     = 4;
  localparam int    SPB    = 4;
  localparam int    SW     = 2;
  localparam longint THR   = longint'(CLK_HZ) * 60;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    bpm;
  logic [6:0]    loops;
  logic          start, pause, stop;
  logic          step_tick, playing, paused, done, cfg_err;
  logic [SW-1:0] step_idx;
  logic [6:0]    loop_count;

  step_scheduler #(.CLK_HZ(CLK_HZ), .NUM_STEPS(NS), .STEPS_PER_BEAT(SPB), .STEP_W(SW)) dut (
    .CLOCK_50(clk), .nReset(rst_n), .BPM(bpm), .Loops(loops),
    .start(start), .pause(pause), .stop(stop),
    .step_tick(step_tick), .step_idx(step_idx), .loop_count(loop_count),
    .playing(playing), .paused(paused), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: playback rules expressed directly on integers.
  int     m_st, m_bpm, m_loops, m_idx, m_lc;
  longint m_acc;
  bit     m_tick, m_done, m_err;

  function automatic void model_reset();
    m_st = M_IDLE; m_acc = 0; m_bpm = 0; m_loops = 0; m_idx = 0; m_lc = 0;
    m_tick = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void model_edge(bit s, bit p, bit t, int b, int l);
    longint inc = longint'(m_bpm) * SPB;
    m_tick = 0; m_done = 0; m_err = 0;
    if (t) begin
      m_st = M_IDLE; m_acc = 0; m_idx = 0; m_lc = 0;
    end else if (p && m_st == M_PLAY) begin
      m_st = M_PAUSE;
    end else if (m_st == M_PLAY) begin
      if (m_acc + inc >= THR) begin
        m_acc = m_acc + inc - THR;
        if (b != 0) m_bpm = b;
        if (m_idx != NS - 1) begin
          m_idx++; m_tick = 1;
        end else begin
          m_idx = 0;
          if (m_lc < 127) m_lc++;
          if (m_loops != 0 && m_lc == m_loops) begin m_st = M_DONE; m_done = 1; end
          else m_tick = 1;
        end
      end else m_acc = m_acc + inc;
    end else if (s && m_st == M_PAUSE) begin
      m_st = M_PLAY;
      if (b != 0) m_bpm = b;
    end else if (s) begin
      if (b == 0) m_err = 1;
      else begin
        m_st = M_PLAY; m_acc = 0; m_idx = 0; m_lc = 0; m_tick = 1; m_bpm = b; m_loops = l;
      end
    end
  endfunction

  int cycle = 0;
  int last_tick = -1;
  int n_ticks = 0;
  int ticks_at_done = -1;
  int iv[$];

  function automatic void clear_iv();
    iv.delete(); last_tick = -1; n_ticks = 0; ticks_at_done = -1;
  endfunction

  task automatic cyc(input bit s, input bit p, input bit t);
    start = s; pause = p; stop = t;
    @(posedge clk);
    model_edge(s, p, t, int'(bpm), int'(loops));
    cycle++;
    #1;
    check("step_tick", step_tick, m_tick);
    check("step_idx", step_idx, m_idx);
    check("loop_count", loop_count, m_lc);
    check("playing", playing, m_st == M_PLAY);
    check("paused", paused, m_st == M_PAUSE);
    check("done", done, m_done);
    check("cfg_err", cfg_err, m_err);
    if (step_tick === 1'b1) begin
      if (last_tick >= 0) iv.push_back(cycle - last_tick);
      last_tick = cycle;
      n_ticks++;
    end
    if (done === 1'b1 && ticks_at_done < 0) ticks_at_done = n_ticks;
    start = 0; pause = 0; stop = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int sum, cnt, idx_save;
    bpm = 10'd0; loops = 7'd0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick", step_tick, 0);
    check("rst_idx", step_idx, 0);
    check("rst_lc", loop_count, 0);
    check("rst_flags", {playing, paused, done, cfg_err}, 0);
    rst_n = 1'b1;
    idle(2);

    // BPM 60: first tick one cycle after start, then one every 60 cycles.
    bpm = 10'd60; loops = 7'd0; clear_iv();
    cyc(1'b1, 1'b0, 1'b0);
    check("first_tick", step_tick, 1);
    check("first_idx", step_idx, 0);
    idle(250);
    check("bpm60_nticks", iv.size(), 4);
    foreach (iv[i]) check("bpm60_period", iv[i], 60);
    cyc(1'b0, 1'b0, 1'b1);

    // BPM 7: 514/515-cycle steps, exact long-run average.
    bpm = 10'd7; clear_iv();
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60000 && n_ticks < 101; i++) cyc(1'b0, 1'b0, 1'b0);
    check("bpm7_nticks", n_ticks, 101);
    sum = 0;
    foreach (iv[i]) begin
      check("bpm7_period", (iv[i] == 514 || iv[i] == 515), 1);
      sum += iv[i];
      if (i == 13) check("bpm7_sum14", sum, 7200);
    end
    check("bpm7_sum100", sum, 51429);
    cyc(1'b0, 1'b0, 1'b1);

    // Loops=2: eight ticks then done, restart clears loop_count.
    bpm = 10'd60; loops = 7'd2; clear_iv();
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 700 && ticks_at_done < 0; i++) cyc(1'b0, 1'b0, 1'b0);
    check("loops_ticks_before_done", ticks_at_done, 8);
    check("loops_lc_at_done", loop_count, 2);
    check("loops_tick_at_done", step_tick, 0);
    idle(5);
    check("done_lc_hold", loop_count, 2);
    check("done_not_playing", playing, 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("restart_lc", loop_count, 0);
    check("restart_tick", step_tick, 1);
    cyc(1'b0, 1'b0, 1'b1);

    // Pause 20 cycles after a tick, hold 1000, resume.
    bpm = 10'd60; loops = 7'd0; clear_iv();
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200 && n_ticks < 2; i++) cyc(1'b0, 1'b0, 1'b0);
    idx_save = int'(step_idx);
    idle(20);
    cyc(1'b0, 1'b1, 1'b0);
    check("pause_state", paused, 1);
    cnt = n_ticks;
    idle(1000);
    check("pause_no_ticks", n_ticks, cnt);
    cyc(1'b1, 1'b0, 1'b0);
    check("resume_playing", playing, 1);
    check("resume_no_tick", step_tick, 0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cnt++;
      if (step_tick === 1'b1) break;
    end
    check("resume_latency", cnt, 40);
    check("resume_idx", step_idx, (idx_save + 1) % NS);
    idle(7);
    cyc(1'b0, 1'b1, 1'b1);
    check("pause_stop_idle", {playing, paused}, 0);
    check("pause_stop_idx", step_idx, 0);

    // Start with BPM 0 is rejected.
    bpm = 10'd0;
    cyc(1'b1, 1'b0, 1'b0);
    check("bpm0_err", cfg_err, 1);
    check("bpm0_idle", playing, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("bpm0_err_pulse", cfg_err, 0);

    // Tempo change mid-step applies from the next step.
    bpm = 10'd60; clear_iv();
    cyc(1'b1, 1'b0, 1'b0);
    idle(10);
    bpm = 10'd120;
    for (int i = 0; i < 300 && n_ticks < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    check("bpm_sw_nticks", iv.size(), 3);
    if (iv.size() == 3) begin
      check("bpm_sw_cur", iv[0], 60);
      check("bpm_sw_next1", iv[1], 30);
      check("bpm_sw_next2", iv[2], 30);
    end

    // Asynchronous reset mid-step.
    idle(25);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tick", step_tick, 0);
    check("arst_idx", step_idx, 0);
    check("arst_lc", loop_count, 0);
    check("arst_flags", {playing, paused, done, cfg_err}, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    bpm = 10'd60;
    cyc(1'b1, 1'b0, 1'b0);
    check("post_rst_tick", step_tick, 1);
    check("post_rst_idx", step_idx, 0);
    idle(3);
    cyc(1'b0, 1'b0, 1'b1);

    // Random control pulses, tempo and loop settings.
    for (int i = 0; i < 4000; i++) begin
      int r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 39) == 0)
        bpm = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(100, 1023));
      if ($urandom_range(0, 99) == 0) loops = 7'($urandom_range(0, 3));
      cyc(r < 4, r >= 4 && r < 6, r == 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
